// File: rtl/bram_tile_pkg.sv
// Shared types and elaboration helpers for the BRAM tile loader.
//   tile_state_e : loader FSM states
//   beat_w_f     : beat counter width, max(1, clog2(beats))
//   is_pow2_f    : power-of-two test used by the parameter legality checks
//   addr_fits_f  : {sel, beat} must fit in the BRAM address
package bram_tile_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } tile_state_e;

  function automatic int beat_w_f(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic bit is_pow2_f(input int v);
    return (v >= 1) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit addr_fits_f(input int addr_w, input int sel_w, input int beats);
    return addr_w >= (sel_w + beat_w_f(beats));
  endfunction

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// Read tag pipe: delays a {valid, tag} pair by RD_LAT cycles so that each
// BRAM read can be matched with the data it returns.
//   clk, rst      : clock, async active-high reset
//   push, tag     : a read is issued this cycle with this tag
//   flush         : drop every read in flight (wins over push)
//   out_vld, out_tag : tag whose data is on the BRAM output this cycle
module bram_rd_tag_pipe #(
  parameter int RD_LAT = 2,
  parameter int TAG_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [TAG_W-1:0] tag,
  input  logic             flush,
  output logic             out_vld,
  output logic [TAG_W-1:0] out_tag
);

  logic [RD_LAT-1:0]            vld_q, vld_d;
  logic [RD_LAT-1:0][TAG_W-1:0] tag_q, tag_d;

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    vld_d[0] = push;
    tag_d[0] = tag;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
    if (flush) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign out_vld = vld_q[RD_LAT-1];
  assign out_tag = tag_q[RD_LAT-1];

endmodule

// File: rtl/bram_tile_loader.sv
// Tile fetcher: on I_START reads BEATS consecutive words of the selected
// tile from a single-port BRAM (one read per cycle) and scatters them into
// a ROWS x COLS matrix, then presents it with a valid/ready handshake.
//   I_CLK, I_RST          : clock, async active-high reset
//   I_START, I_SEL        : job request and tile index
//   O_BUSY                : issuing or draining reads
//   O_VLD, I_RDY          : tile complete / consumer accept
//   O_ABORT               : one-cycle pulse when a start cancels a job/result
//   O_MAT                 : output tile, O_MAT[row][col]
//   O_RAM_EN, O_RAM_ADDR  : BRAM read port, address = {pad, sel, beat}
//   I_RAM_DOUT            : BRAM data, RD_LAT cycles after the read
//
// state   | meaning
// S_IDLE  | no job, result (if any) already accepted
// S_ISSUE | one BRAM read per cycle, beats 0..BEATS-1
// S_DRAIN | all reads issued, waiting for the remaining data
// S_OUT   | tile complete, O_VLD held until I_RDY
module bram_tile_loader
  import bram_tile_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int COLS          = 128,
  parameter int ROWS_PER_WORD = 4,
  parameter int BEATS         = 4,
  parameter int SEL_W         = 6,
  parameter int ADDR_W        = 10,
  parameter int RD_LAT        = 2
) (
  input  logic                                                I_CLK,
  input  logic                                                I_RST,
  input  logic                                                I_START,
  input  logic [SEL_W-1:0]                                    I_SEL,
  output logic                                                O_BUSY,
  output logic                                                O_VLD,
  input  logic                                                I_RDY,
  output logic                                                O_ABORT,
  output logic [ROWS_PER_WORD*BEATS-1:0][COLS-1:0][DATA_W-1:0] O_MAT,
  output logic                                                O_RAM_EN,
  output logic [ADDR_W-1:0]                                   O_RAM_ADDR,
  input  logic [DATA_W*COLS*ROWS_PER_WORD-1:0]                I_RAM_DOUT
);

  localparam int ROWS   = ROWS_PER_WORD * BEATS;
  localparam int BEAT_W = beat_w_f(BEATS);
  localparam int WORD_W = DATA_W * COLS * ROWS_PER_WORD;
  localparam int MAT_W  = WORD_W * BEATS;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if (!is_pow2_f(BEATS)) begin : g_chk_beats
    $error("bram_tile_loader: BEATS must be a power of two >= 1");
  end
  if (RD_LAT < 1) begin : g_chk_lat
    $error("bram_tile_loader: RD_LAT must be >= 1");
  end
  if (!addr_fits_f(ADDR_W, SEL_W, BEATS)) begin : g_chk_addr
    $error("bram_tile_loader: ADDR_W too small for {sel, beat}");
  end

  tile_state_e       state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [BEAT_W-1:0] cap_q, cap_d;
  logic              abort_q, abort_d;
  logic [MAT_W-1:0]  mat_q, mat_d;

  logic              ram_en;
  logic              busy;
  logic              vld;
  logic              flush;
  logic              cap_en;
  logic              pipe_vld;
  logic [BEAT_W-1:0] pipe_tag;

  assign ram_en = (state_q == S_ISSUE);
  assign busy   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign vld    = (state_q == S_OUT);
  // A restart edge must never write data belonging to the cancelled job.
  assign cap_en = pipe_vld && !I_START;

  bram_rd_tag_pipe #(
    .RD_LAT (RD_LAT),
    .TAG_W  (BEAT_W)
  ) u_tag_pipe (
    .clk     (I_CLK),
    .rst     (I_RST),
    .push    (ram_en),
    .tag     (beat_q),
    .flush   (flush),
    .out_vld (pipe_vld),
    .out_tag (pipe_tag)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    beat_d  = beat_q;
    cap_d   = cap_q;
    abort_d = 1'b0;
    mat_d   = mat_q;
    flush   = 1'b0;

    if (cap_en) begin
      mat_d[int'(pipe_tag) * WORD_W +: WORD_W] = I_RAM_DOUT;
      if (cap_q != LAST_BEAT) begin
        cap_d = cap_q + 1'b1;
      end
    end

    case (state_q)
      S_ISSUE: begin
        if (beat_q == LAST_BEAT) begin
          state_d = S_DRAIN;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Captures are in beat order, so the last one completes the tile.
        if (cap_en && (cap_q == LAST_BEAT)) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (I_RDY) begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    if (I_START) begin
      sel_d   = I_SEL;
      beat_d  = '0;
      cap_d   = '0;
      flush   = 1'b1;
      state_d = S_ISSUE;
      abort_d = busy || (vld && !I_RDY);
    end
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      beat_q  <= '0;
      cap_q   <= '0;
      abort_q <= 1'b0;
      mat_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      beat_q  <= beat_d;
      cap_q   <= cap_d;
      abort_q <= abort_d;
      mat_q   <= mat_d;
    end
  end

  assign O_BUSY     = busy;
  assign O_VLD      = vld;
  assign O_ABORT    = abort_q;
  assign O_MAT      = mat_q;
  assign O_RAM_EN   = ram_en;
  assign O_RAM_ADDR = ADDR_W'({sel_q, beat_q});

endmodule

// File: tb/tb_bram_tile_loader.sv
module tb_bram_tile_loader;

  // instance A: default parameters
  localparam int RPW_A = 4, BEATS_A = 4, COLS_A = 128, LATR_A = 2;
  localparam int LAT_A = BEATS_A + LATR_A + 1;
  localparam int ROWW_A = COLS_A * 8;
  localparam int ROWS_A = RPW_A * BEATS_A;
  // instance B: deeper latency, more beats
  localparam int RPW_B = 2, BEATS_B = 8, COLS_B = 16, LATR_B = 4;
  localparam int LAT_B = BEATS_B + LATR_B + 1;
  localparam int ROWW_B = COLS_B * 8;
  localparam int ROWS_B = RPW_B * BEATS_B;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start_a, rdy_a, busy_a, vld_a, abort_a, ram_en_a;
  logic [5:0] sel_a;
  logic [9:0] ram_addr_a;
  logic [ROWS_A*ROWW_A-1:0] mat_a;
  logic [RPW_A*ROWW_A-1:0] dout_a;

  logic start_b, rdy_b, busy_b, vld_b, abort_b, ram_en_b;
  logic [5:0] sel_b;
  logic [9:0] ram_addr_b;
  logic [ROWS_B*ROWW_B-1:0] mat_b;
  logic [RPW_B*ROWW_B-1:0] dout_b;

  int n_vec = 0;
  int n_err = 0;

  bram_tile_loader dut_a (
    .I_CLK(clk), .I_RST(rst), .I_START(start_a), .I_SEL(sel_a),
    .O_BUSY(busy_a), .O_VLD(vld_a), .I_RDY(rdy_a), .O_ABORT(abort_a),
    .O_MAT(mat_a), .O_RAM_EN(ram_en_a), .O_RAM_ADDR(ram_addr_a),
    .I_RAM_DOUT(dout_a)
  );

  bram_tile_loader #(
    .DATA_W(8), .COLS(COLS_B), .ROWS_PER_WORD(RPW_B), .BEATS(BEATS_B),
    .SEL_W(6), .ADDR_W(10), .RD_LAT(LATR_B)
  ) dut_b (
    .I_CLK(clk), .I_RST(rst), .I_START(start_b), .I_SEL(sel_b),
    .O_BUSY(busy_b), .O_VLD(vld_b), .I_RDY(rdy_b), .O_ABORT(abort_b),
    .O_MAT(mat_b), .O_RAM_EN(ram_en_b), .O_RAM_ADDR(ram_addr_b),
    .I_RAM_DOUT(dout_b)
  );

  // BRAM content: byte at (address, row-in-word, column)
  function automatic logic [7:0] pat(input int a, input int r, input int c);
    return 8'((a * 13 + r * 7 + c * 3 + 1) & 255);
  endfunction

  // RAM models: a read presented in cycle t returns data in cycle t+latency
  bit         hv_a [LATR_A];
  logic [9:0] ha_a [LATR_A];
  bit         hv_b [LATR_B];
  logic [9:0] ha_b [LATR_B];
  logic [31:0] junk = 32'h5a5a_1234;

  always @(posedge clk) begin
    hv_a[0] <= ram_en_a;
    ha_a[0] <= ram_addr_a;
    for (int i = 1; i < LATR_A; i++) begin
      hv_a[i] <= hv_a[i-1];
      ha_a[i] <= ha_a[i-1];
    end
    hv_b[0] <= ram_en_b;
    ha_b[0] <= ram_addr_b;
    for (int i = 1; i < LATR_B; i++) begin
      hv_b[i] <= hv_b[i-1];
      ha_b[i] <= ha_b[i-1];
    end
    junk <= $urandom;
  end

  always_comb begin
    dout_a = '0;
    for (int r = 0; r < RPW_A; r++)
      for (int c = 0; c < COLS_A; c++)
        dout_a[(r*COLS_A+c)*8 +: 8] = hv_a[LATR_A-1] ? pat(int'(ha_a[LATR_A-1]), r, c)
                                                     : (junk[7:0] ^ 8'(c));
  end

  always_comb begin
    dout_b = '0;
    for (int r = 0; r < RPW_B; r++)
      for (int c = 0; c < COLS_B; c++)
        dout_b[(r*COLS_B+c)*8 +: 8] = hv_b[LATR_B-1] ? pat(int'(ha_b[LATR_B-1]), r, c)
                                                     : (junk[15:8] ^ 8'(c));
  end

  // Expected tile rows: matrix row = beat*RPW + row-in-word, beat word at sel*BEATS+beat
  function automatic logic [ROWW_A-1:0] exp_row_a(input int s, input int row);
    logic [ROWW_A-1:0] v;
    int a;
    a = s * BEATS_A + row / RPW_A;
    for (int c = 0; c < COLS_A; c++) v[c*8 +: 8] = pat(a, row % RPW_A, c);
    return v;
  endfunction

  function automatic logic [ROWW_B-1:0] exp_row_b(input int s, input int row);
    logic [ROWW_B-1:0] v;
    int a;
    a = s * BEATS_B + row / RPW_B;
    for (int c = 0; c < COLS_B; c++) v[c*8 +: 8] = pat(a, row % RPW_B, c);
    return v;
  endfunction

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_rows_a(input int s);
    logic [ROWW_A-1:0] er;
    for (int row = 0; row < ROWS_A; row++) begin
      er = exp_row_a(s, row);
      check($sformatf("a_row%0d_lo", row), mat_a[row*ROWW_A +: 512], er[511:0]);
      check($sformatf("a_row%0d_hi", row), mat_a[row*ROWW_A+512 +: 512], er[1023:512]);
    end
  endtask

  // Starts a job in the current cycle (cycle 0) and runs to the first O_VLD cycle.
  task automatic job_a(input logic [5:0] s, input bit exp_abort);
    int n, nis, spur, busy_bad;
    sel_a = s;
    start_a = 1'b1;
    @(negedge clk);
    cyc();
    start_a = 1'b0;
    rdy_a = 1'b0;
    n = 1; nis = 0; spur = 0; busy_bad = 0;
    @(negedge clk);
    check("a_abort_pulse", abort_a, exp_abort);
    while (1) begin
      if (n > 1 && abort_a) spur++;
      if (busy_a !== (n < LAT_A)) busy_bad++;
      if (ram_en_a) begin
        check("a_issue_addr", ram_addr_a, int'(s) * BEATS_A + nis);
        check("a_issue_cyc", n, 1 + nis);
        nis++;
      end
      if (vld_a || n >= 40) break;
      cyc();
      n++;
      @(negedge clk);
    end
    check("a_vld_latency", n, LAT_A);
    check("a_issue_count", nis, BEATS_A);
    check("a_abort_spurious", spur, 0);
    check("a_busy_profile", busy_bad, 0);
    cmp_rows_a(s);
  endtask

  // Holds I_RDY low for 'hold' cycles, then accepts; ends at the start of an idle cycle.
  task automatic accept_a(input logic [5:0] s, input int hold);
    logic [ROWW_A-1:0] er;
    int rr;
    for (int h = 0; h < hold; h++) begin
      cyc();
      @(negedge clk);
      check("a_hold_vld", vld_a, 1'b1);
      rr = $urandom_range(0, ROWS_A - 1);
      er = exp_row_a(s, rr);
      check("a_hold_row", mat_a[rr*ROWW_A +: 512], er[511:0]);
    end
    cyc();
    rdy_a = 1'b1;
    @(negedge clk);
    cyc();
    rdy_a = 1'b0;
    @(negedge clk);
    check("a_vld_after_acc", vld_a, 1'b0);
    check("a_busy_after_acc", busy_a, 1'b0);
    check("a_abort_after_acc", abort_a, 1'b0);
    er = exp_row_a(s, ROWS_A - 1);
    check("a_mat_kept", mat_a[(ROWS_A-1)*ROWW_A +: 512], er[511:0]);
    cyc();
  endtask

  // First job, then a second start d cycles later with I_RDY=r at that edge.
  task automatic restart_a(input logic [5:0] s1, input logic [5:0] s2, input int d, input bit r);
    rdy_a = 1'b0;
    sel_a = s1;
    start_a = 1'b1;
    @(negedge clk);
    cyc();
    start_a = 1'b0;
    for (int i = 1; i < d; i++) begin
      @(negedge clk);
      cyc();
    end
    rdy_a = r;
    job_a(s2, !(d >= LAT_A && r));
    accept_a(s2, 0);
  endtask

  task automatic job_b(input logic [5:0] s);
    int n, nis;
    logic [ROWW_B-1:0] er;
    sel_b = s;
    start_b = 1'b1;
    @(negedge clk);
    cyc();
    start_b = 1'b0;
    n = 1; nis = 0;
    @(negedge clk);
    while (1) begin
      if (ram_en_b) begin
        check("b_issue_addr", ram_addr_b, int'(s) * BEATS_B + nis);
        check("b_issue_cyc", n, 1 + nis);
        nis++;
      end
      if (vld_b || n >= 60) break;
      cyc();
      n++;
      @(negedge clk);
    end
    check("b_vld_latency", n, LAT_B);
    check("b_issue_count", nis, BEATS_B);
    for (int row = 0; row < ROWS_B; row++) begin
      er = exp_row_b(s, row);
      check($sformatf("b_row%0d", row), mat_b[row*ROWW_B +: ROWW_B], er);
    end
    cyc();
    rdy_b = 1'b1;
    @(negedge clk);
    cyc();
    rdy_b = 1'b0;
    @(negedge clk);
    check("b_vld_after_acc", vld_b, 1'b0);
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] s1, s2, rs;
    rst = 1'b1;
    start_a = 1'b0; rdy_a = 1'b0; sel_a = '0;
    start_b = 1'b0; rdy_b = 1'b0; sel_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy_a, 1'b0);
    check("rst_vld", vld_a, 1'b0);
    check("rst_abort", abort_a, 1'b0);
    check("rst_ram_en", ram_en_a, 1'b0);
    check("rst_ram_addr", ram_addr_a, 0);
    check("rst_mat", mat_a[511:0], 0);
    check("rst_vld_b", vld_b, 1'b0);
    cyc();
    rst = 1'b0;
    cyc();

    // sel=5: addresses 20..23, O_VLD at cycle 7, held 10 cycles before accept
    job_a(6'd5, 1'b0);
    accept_a(6'd5, 10);

    for (int i = 0; i < 6; i++) begin
      s1 = 6'($urandom_range(0, 63));
      job_a(s1, 1'b0);
      accept_a(s1, $urandom_range(0, 4));
    end

    // restart at cycle 3: abort pulse at cycle 4, tile from sel=2 only
    restart_a(6'd1, 6'd2, 3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      s1 = 6'($urandom_range(0, 63));
      s2 = 6'($urandom_range(0, 63));
      restart_a(s1, s2, $urandom_range(1, LAT_A + 3), 1'($urandom_range(0, 1)));
    end

    // start together with I_RDY in S_OUT: accepted, no abort
    job_a(6'd7, 1'b0);
    cyc();
    rdy_a = 1'b1;
    job_a(6'd8, 1'b0);
    accept_a(6'd8, 0);

    // asynchronous reset in cycle 4 of a job
    sel_a = 6'd9;
    start_a = 1'b1;
    @(negedge clk);
    cyc();
    start_a = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      cyc();
    end
    #1 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy_a, 1'b0);
    check("mid_rst_vld", vld_a, 1'b0);
    check("mid_rst_abort", abort_a, 1'b0);
    check("mid_rst_ram_en", ram_en_a, 1'b0);
    check("mid_rst_ram_addr", ram_addr_a, 0);
    check("mid_rst_mat_lo", mat_a[511:0], 0);
    check("mid_rst_mat_hi", mat_a[1023:512], 0);
    cyc();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy_a, 1'b0);
    cyc();
    rs = 6'($urandom_range(0, 63));
    job_a(rs, 1'b0);
    accept_a(rs, 0);

    for (int i = 0; i < 3; i++) job_b(6'($urandom_range(0, 63)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_tile_loader.md
Name: bram_tile_loader

Overview:
- Parametrised tile fetcher. On a start pulse it reads BEATS consecutive wide words from an external single-port BRAM and scatters them into a ROWS = ROWS_PER_WORD*BEATS by COLS output matrix of DATA_W elements.
- Generalises the fixed 16x128x8 / 2-cycle-latency loader: configurable read latency, pipelined one-read-per-cycle issue, valid/ready output handshake, and an explicit abort indication.
- Sits between the weight/activation BRAM and the attention datapath.

Parameters:
- DATA_W, 8: element width in bits.
- COLS, 128: elements per matrix row.
- ROWS_PER_WORD, 4: matrix rows packed in one BRAM word.
- BEATS, 4: BRAM words per tile. Must be a power of two and >= 1.
- SEL_W, 6: tile-select width.
- ADDR_W, 10: BRAM address width. Must satisfy ADDR_W >= SEL_W + BEAT_W, where BEAT_W = max(1, clog2(BEATS)).
- RD_LAT, 2: BRAM read latency in cycles. Must be >= 1.

Ports:
- I_CLK, in, 1: clock.
- I_RST, in, 1: reset, asynchronous, active-high.
- I_START, in, 1: single-cycle job request.
- I_SEL, in, SEL_W: tile index, sampled only when I_START=1.
- O_BUSY, in-flight indicator, out, 1: high while a job is issuing or draining.
- O_VLD, out, 1: tile complete; held until accepted.
- I_RDY, in, 1: consumer accept.
- O_ABORT, out, 1: one-cycle pulse when I_START cancels a busy job or an unaccepted result.
- O_MAT, out, DATA_W x [ROWS][COLS]: output tile.
- O_RAM_EN, out, 1: BRAM read enable.
- O_RAM_ADDR, out, ADDR_W: BRAM address = {zero pad, sel_q, beat}.
- I_RAM_DOUT, in, DATA_W*COLS*ROWS_PER_WORD: BRAM read data. Row r, column c lives at bits [(r*COLS+c)*DATA_W +: DATA_W].

Behaviour:
- Reset (I_RST=1, asynchronous): state=S_IDLE; O_BUSY, O_VLD, O_ABORT, O_RAM_EN = 0; O_RAM_ADDR=0; O_MAT all zero; tag pipe cleared. Takes effect immediately, including mid-job. In-flight reads are discarded.
- States: S_IDLE, S_ISSUE, S_DRAIN, S_OUT.
- I_START sampled at edge E0:
  - sel_q <= I_SEL; issue counter <= 0; tag pipe flushed; O_VLD <= 0; state <= S_ISSUE.
  - This applies from every state. I_START has priority over all other events.
- S_ISSUE: O_RAM_EN=1 with beat = 0..BEATS-1 in cycles 1..BEATS after E0, one per cycle. After the last beat issues, go to S_DRAIN.
- Tag pipe: RD_LAT-deep {valid, beat} shift register. Data for beat k appears on I_RAM_DOUT in cycle 1+k+RD_LAT. It is captured at the end of that cycle into O_MAT rows [k*ROWS_PER_WORD +: ROWS_PER_WORD].
- S_DRAIN: O_RAM_EN=0. Wait until the capture count reaches BEATS, then go to S_OUT with O_VLD=1.
- First O_VLD cycle is BEATS+RD_LAT+1 after the start cycle. Defaults give 7.
- O_BUSY=1 in S_ISSUE and S_DRAIN, 0 otherwise.
- S_OUT: O_VLD=1 and O_MAT stable until the cycle with I_RDY=1. On that edge O_VLD <= 0 and state <= S_IDLE.
  - I_RDY is ignored when O_VLD=0.
  - O_MAT keeps its last value after acceptance.
- Abort: I_START while O_BUSY=1, or while O_VLD=1 and I_RDY=0, causes:
  - O_ABORT=1 for the next cycle.
  - Old reads flushed; no stale beat is ever written after the restart edge.
  - Old result dropped.
- I_START and I_RDY both high in S_OUT: the result counts as accepted, O_ABORT=0, and the new job starts.
- O_MAT is undefined-content but not valid while O_BUSY=1: partial overwrite is permitted.
- Width rules: beat counter is BEAT_W bits and never wraps within a job. The address zero-extends {sel_q, beat} to ADDR_W.

Decomposition:
- Package bram_tile_pkg: state enum; a clog2-based BEAT_W helper function; parameter legality checks (elaboration-time assertions on BEATS power of two, RD_LAT >= 1, ADDR_W bound).
- One sub-module: bram_rd_tag_pipe (parameters RD_LAT, TAG_W). Inputs: push, tag, flush. Outputs: {valid, tag} delayed by RD_LAT.

Test Plan:
- Defaults; RAM model with latency 2 where word at address a has all bytes = a[7:0]. I_START with I_SEL=5 at cycle 0 -> addresses 20,21,22,23 in cycles 1-4; O_VLD=1 at cycle 7; rows 0-3 = 0x14, rows 12-15 = 0x17.
- Hold I_RDY=0 for 10 cycles after O_VLD -> O_VLD and O_MAT stay constant. I_RDY=1 -> O_VLD=0 on the next cycle, state idle.
- I_START(sel=1) at cycle 0, then I_START(sel=2) at cycle 3 -> O_ABORT pulse at cycle 4; final O_MAT rows hold only bytes 0x08-0x0B; O_VLD at cycle 10.
- Assert I_RST at cycle 4 of a job -> all outputs 0 immediately. A later start completes normally with no stale beat.
- RD_LAT=4, BEATS=8, ROWS_PER_WORD=2 -> O_VLD at cycle 13; 16 rows correctly ordered.
- I_START together with I_RDY in S_OUT -> no O_ABORT; the new job completes 7 cycles later.
